lsu_data_port: RTL and testbench
================================

Name: lsu_data_port

Overview:
Load/store data port that consumes the memory-access select codes produced by the ALU controller (ReadDataSelect, WriteDataSelect) and executes the access against a word-wide data memory.
- Stores: steers write data onto byte lanes and generates byte enables.
- Loads: extracts and sign- or zero-extends the returned lane.
- Runs a request/acknowledge handshake toward memory, and a valid/ready handshake toward the pipeline.

Parameters:
ADDR_W, 32, byte-address width.
TIMEOUT, 16, max cycles waiting for mem_ack before an error response (≥1).

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
req_valid  in  1  pipeline presents an access.
req_ready  out  1  block can accept an access.
ReadFlag  in  1  access is a load.
WriteFlag  in  1  access is a store.
addr  in  ADDR_W  byte address (ALU result).
wdata  in  32  store data (rs2).
ReadDataSelect  in  3  load type: 000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU.
WriteDataSelect  in  2  store type: 00 SW, 01 SB, 10 SH.
resp_valid  out  1  one-cycle completion pulse.
rdata  out  32  extended load data; 0 for stores and errors.
err  out  1  qualifies resp_valid.
mem_req  out  1  memory request.
mem_we  out  1  1 = write.
mem_addr  out  ADDR_W  word-aligned byte address (low 2 bits 0).
mem_be  out  4  byte enables.
mem_wdata  out  32  lane-steered write data.
mem_ack  in  1  memory completion.
mem_rdata  in  32  read word, valid with mem_ack.

Behaviour:
- Reset (async, immediate):
  - state IDLE.
  - req_ready = 1 once reset deasserts.
  - All other outputs 0: resp_valid, err, rdata, mem_req, mem_we, mem_addr, mem_be, mem_wdata.
  - Timeout counter 0.
  - Reset mid-access drops mem_req the same instant. The access is lost and no response is issued.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - req_ready = 1.
  - Accept on req_valid & req_ready: latch the access and classify it.
  - Error check, in order:
    - ReadFlag == WriteFlag → error.
    - Load with ReadDataSelect ≥ 101, or store with WriteDataSelect == 11 → error.
    - Misaligned → error: halfword with addr[0] = 1; word with addr[1:0] ≠ 00.
  - On error: go to RESP with err = 1. No memory access is issued.
  - Otherwise: go to REQ. mem_req and all mem_* outputs are registered and assert the next cycle.
- REQ:
  - req_ready = 0.
  - mem_req, mem_we, mem_addr, mem_be, mem_wdata held stable until mem_ack.
  - On mem_ack:
    - Drop mem_req next cycle.
    - Load: register the extracted mem_rdata into rdata.
    - Go to RESP with err = 0.
  - Counter increments each REQ cycle without ack. If it reaches TIMEOUT: drop mem_req, go to RESP with err = 1, rdata = 0.
  - An ack in the same cycle the counter would reach TIMEOUT wins (success).
- RESP:
  - resp_valid = 1 for exactly one cycle, then IDLE.
  - req_ready = 0.
  - rdata/err hold until the next response.
- mem_ack outside REQ is ignored.
- Latency:
  - Accept cycle 0 → mem_req cycle 1.
  - Ack in cycle N → resp_valid in cycle N+1.
  - Minimum 2 cycles. Throughput: one access per 3 cycles.
- Store steering (off = addr[1:0]):
  - SW: be = 1111, data unchanged.
  - SH: be = 0011 if off[1] = 0, else 1100; wdata[15:0] replicated into both halves.
  - SB: be = 0001 << off; wdata[7:0] replicated into all four lanes.
- Loads: mem_we = 0, mem_be = 1111.
  - Byte lane = off; halfword lane = off[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW is passthrough.
- mem_addr = {addr[ADDR_W-1:2], 2'b00}.

Decomposition:
- Package riscv_lsu_pkg:
  - Enum rd_sel_e (LW=000, LB=001, LBU=010, LH=011, LHU=100).
  - Enum wr_sel_e (SW=00, SB=01, SH=10).
  - Enum lsu_state_e (IDLE, REQ, RESP).
  - Constant for the byte-enable width (4).
- Sub-module lsu_align, purely combinational, holding the shared lane math. It:
  - produces store byte enables and steered data;
  - extracts and extends load data;
  - flags misalignment and illegal codes.
- Top holds the FSM, timeout counter and registers.

Test Plan:
- SB: WriteFlag = 1, addr 0x1003, wdata 0x000000AB → mem_addr 0x1000, mem_be 1000, mem_wdata 0xABABABAB, mem_we 1. Ack on first mem_req cycle → resp_valid 2 cycles after accept, err 0.
- LB then LBU: addr 0x2002, mem_rdata 0x12F45678 → rdata 0xFFFFFFF4, then 0x000000F4. mem_be 1111, mem_we 0.
- LH at addr 0x2001 → mem_req never asserts; resp_valid cycle 1 with err 1, rdata 0. Repeat with ReadFlag = WriteFlag = 1 → same response.
- LHU addr 0x2002, mem_rdata 0x80017FFF, ack delayed 5 cycles → mem_* stable all 5 cycles, rdata 0x00008001. Spurious mem_ack while IDLE → no response.
- Timeout (TIMEOUT = 16), no ack → mem_req high 16 cycles then low; resp_valid with err 1. Next access accepted normally.
- Reset asserted in REQ → mem_req 0 immediately, no resp_valid. After release, req_ready 1 and an SW to 0x40 completes with mem_be 1111.

Source files
------------

// File: rtl/riscv_lsu_pkg.sv
// Shared types and helpers for the load/store data port.
package riscv_lsu_pkg;

  // Number of byte lanes in one memory word.
  localparam int BE_W = 4;

  // Load type codes from the ALU controller.
  typedef enum logic [2:0] {
    LW  = 3'b000,
    LB  = 3'b001,
    LBU = 3'b010,
    LH  = 3'b011,
    LHU = 3'b100
  } rd_sel_e;

  // Store type codes from the ALU controller.
  typedef enum logic [1:0] {
    SW = 2'b00,
    SB = 2'b01,
    SH = 2'b10
  } wr_sel_e;

  // Access sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RESP = 2'b10
  } lsu_state_e;

  // Sign-extend a byte to a word.
  function automatic logic [31:0] sext8(input logic [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

  // Sign-extend a halfword to a word.
  function automatic logic [31:0] sext16(input logic [15:0] h);
    return {{16{h[15]}}, h};
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane math: store steering, load extraction, legality checks.
module lsu_align
  import riscv_lsu_pkg::*;
(
  input  logic            is_load_i,
  input  logic            is_store_i,
  input  logic [1:0]      off_i,
  input  logic [2:0]      rd_sel_i,
  input  logic [1:0]      wr_sel_i,
  input  logic [31:0]     wdata_i,
  input  logic [31:0]     mem_rdata_i,
  output logic [BE_W-1:0] be_o,
  output logic [31:0]     wdata_o,
  output logic [31:0]     rdata_o,
  output logic            misaligned_o,
  output logic            illegal_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Byte enables and replicated write data for the access type.
  always_comb begin
    be_o    = 4'b0000;
    wdata_o = 32'h0000_0000;
    if (is_store_i) begin
      case (wr_sel_i)
        SW: begin
          be_o    = 4'b1111;
          wdata_o = wdata_i;
        end
        SH: begin
          be_o    = off_i[1] ? 4'b1100 : 4'b0011;
          wdata_o = {2{wdata_i[15:0]}};
        end
        SB: begin
          be_o    = 4'b0001 << off_i;
          wdata_o = {4{wdata_i[7:0]}};
        end
        default: begin
          be_o    = 4'b0000;
          wdata_o = 32'h0000_0000;
        end
      endcase
    end else if (is_load_i) begin
      be_o = 4'b1111;
    end else begin
      be_o = 4'b0000;
    end
  end

  // Pick the addressed byte and halfword out of the returned word.
  always_comb begin
    byte_s = 8'h00;
    case (off_i)
      2'b00:   byte_s = mem_rdata_i[7:0];
      2'b01:   byte_s = mem_rdata_i[15:8];
      2'b10:   byte_s = mem_rdata_i[23:16];
      2'b11:   byte_s = mem_rdata_i[31:24];
      default: byte_s = 8'h00;
    endcase
    half_s = off_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
  end

  // Extend the extracted lane according to the load type.
  always_comb begin
    rdata_o = 32'h0000_0000;
    case (rd_sel_i)
      LW:      rdata_o = mem_rdata_i;
      LB:      rdata_o = sext8(byte_s);
      LBU:     rdata_o = {24'h00_0000, byte_s};
      LH:      rdata_o = sext16(half_s);
      LHU:     rdata_o = {16'h0000, half_s};
      default: rdata_o = 32'h0000_0000;
    endcase
  end

  // Flag undefined type codes and accesses that straddle their natural size.
  always_comb begin
    illegal_o    = 1'b0;
    misaligned_o = 1'b0;
    if (is_load_i) begin
      illegal_o = (rd_sel_i > 3'b100);
      case (rd_sel_i)
        LW:      misaligned_o = (off_i != 2'b00);
        LH, LHU: misaligned_o = off_i[0];
        default: misaligned_o = 1'b0;
      endcase
    end else if (is_store_i) begin
      illegal_o = (wr_sel_i == 2'b11);
      case (wr_sel_i)
        SW:      misaligned_o = (off_i != 2'b00);
        SH:      misaligned_o = off_i[0];
        default: misaligned_o = 1'b0;
      endcase
    end else begin
      illegal_o    = 1'b0;
      misaligned_o = 1'b0;
    end
  end

endmodule

// File: rtl/lsu_data_port.sv
// Load/store data port: validates an access, runs it against word memory
// with a bounded wait for acknowledge, and returns a one-cycle response.
module lsu_data_port
  import riscv_lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              ReadFlag,
  input  logic              WriteFlag,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [2:0]        ReadDataSelect,
  input  logic [1:0]        WriteDataSelect,
  output logic              resp_valid,
  output logic [31:0]       rdata,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BE_W-1:0]   mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              resp_valid_q, resp_valid_d;
  logic [1:0]        off_q, off_d;
  logic [2:0]        rd_sel_q, rd_sel_d;
  logic              is_load_q, is_load_d;

  logic              idle_s;
  logic              is_load_s;
  logic [1:0]        off_s;
  logic [2:0]        rd_sel_s;
  logic [BE_W-1:0]   be_s;
  logic [31:0]       wdata_s;
  logic [31:0]       rext_s;
  logic              misaligned_s;
  logic              illegal_s;
  logic              bad_req_s;

  // While idle the lane math looks at the incoming request; afterwards at the latched one.
  assign idle_s    = (state_q == IDLE);
  assign is_load_s = idle_s ? ReadFlag       : is_load_q;
  assign off_s     = idle_s ? addr[1:0]      : off_q;
  assign rd_sel_s  = idle_s ? ReadDataSelect : rd_sel_q;

  lsu_align u_align (
    .is_load_i    (is_load_s),
    .is_store_i   (WriteFlag),
    .off_i        (off_s),
    .rd_sel_i     (rd_sel_s),
    .wr_sel_i     (WriteDataSelect),
    .wdata_i      (wdata),
    .mem_rdata_i  (mem_rdata),
    .be_o         (be_s),
    .wdata_o      (wdata_s),
    .rdata_o      (rext_s),
    .misaligned_o (misaligned_s),
    .illegal_o    (illegal_s)
  );

  assign bad_req_s = (ReadFlag == WriteFlag) | illegal_s | misaligned_s;

  // Next-state and next-output decode for the access sequencer.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    resp_valid_d = 1'b0;
    off_d        = off_q;
    rd_sel_d     = rd_sel_q;
    is_load_d    = is_load_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          off_d     = addr[1:0];
          rd_sel_d  = ReadDataSelect;
          is_load_d = ReadFlag;
          cnt_d     = {CNT_W{1'b0}};
          if (bad_req_s) begin
            state_d      = RESP;
            err_d        = 1'b1;
            rdata_d      = 32'h0000_0000;
            resp_valid_d = 1'b1;
          end else begin
            state_d     = REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = WriteFlag;
            mem_addr_d  = {addr[ADDR_W-1:2], 2'b00};
            mem_be_d    = be_s;
            mem_wdata_d = WriteFlag ? wdata_s : 32'h0000_0000;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (mem_ack || (cnt_q == CNT_LAST)) begin
          // An ack arriving on the last allowed cycle still counts as success.
          state_d      = RESP;
          resp_valid_d = 1'b1;
          cnt_d        = {CNT_W{1'b0}};
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
          mem_addr_d   = {ADDR_W{1'b0}};
          mem_be_d     = 4'b0000;
          mem_wdata_d  = 32'h0000_0000;
          if (mem_ack) begin
            err_d   = 1'b0;
            rdata_d = is_load_q ? rext_s : 32'h0000_0000;
          end else begin
            err_d   = 1'b1;
            rdata_d = 32'h0000_0000;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= {ADDR_W{1'b0}};
      mem_be_q     <= 4'b0000;
      mem_wdata_q  <= 32'h0000_0000;
      rdata_q      <= 32'h0000_0000;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      off_q        <= 2'b00;
      rd_sel_q     <= 3'b000;
      is_load_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      resp_valid_q <= resp_valid_d;
      off_q        <= off_d;
      rd_sel_q     <= rd_sel_d;
      is_load_q    <= is_load_d;
    end
  end

  assign req_ready  = idle_s & ~reset;
  assign resp_valid = resp_valid_q;
  assign rdata      = rdata_q;
  assign err        = err_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_data_port.sv
// Scoreboard bench for lsu_data_port: directed accesses push expected
// responses; a negedge monitor pops and compares each resp_valid.
module tb_lsu_data_port;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        ReadFlag = 1'b0;
  logic        WriteFlag = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [2:0]  ReadDataSelect = 3'b000;
  logic [1:0]  WriteDataSelect = 2'b00;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  lsu_data_port #(.ADDR_W(32), .TIMEOUT(TMO)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .ReadFlag        (ReadFlag),
    .WriteFlag       (WriteFlag),
    .addr            (addr),
    .wdata           (wdata),
    .ReadDataSelect  (ReadDataSelect),
    .WriteDataSelect (WriteDataSelect),
    .resp_valid      (resp_valid),
    .rdata           (rdata),
    .err             (err),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_be          (mem_be),
    .mem_wdata       (mem_wdata),
    .mem_ack         (mem_ack),
    .mem_rdata       (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_resp: got resp_valid=1 err=%0b rdata=0x%08h expected no response", err, rdata);
      end else begin
        mon_e = sb_q.pop_front();
        chk("resp_err", {31'd0, err}, {31'd0, mon_e.err});
        chk("resp_rdata", rdata, mon_e.rdata);
        chk("resp_cycle", cyc, mon_e.cyc);
      end
    end
  end

  // Wait (bounded) until the port is ready, leaving time at posedge+1.
  task automatic wait_ready();
    int k;
    for (k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (req_ready === 1'b1) break;
    end
    if (k == 20) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_ready: got req_ready=0 expected 1 within 20 cycles");
    end
  endtask

  task automatic chk_mem(input logic we, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    chk("mem_req", {31'd0, mem_req}, 32'd1);
    chk("mem_we", {31'd0, mem_we}, {31'd0, we});
    chk("mem_addr", mem_addr, a);
    chk("mem_be", {28'd0, mem_be}, {28'd0, be});
    chk("mem_wdata", mem_wdata, wd);
  endtask

  // dly: >=0 ack after that many mem_req cycles, -1 never ack, -2 rejected (no memory access)
  task automatic do_access(
    input logic rf, input logic wf, input logic [2:0] rsel, input logic [1:0] wsel,
    input logic [31:0] a, input logic [31:0] wd, input int dly, input logic [31:0] mrd,
    input logic ewe, input logic [31:0] eaddr, input logic [3:0] ebe, input logic [31:0] ewd,
    input logic eerr, input logic [31:0] erd);
    exp_t e;
    int   k;
    wait_ready();
    req_valid = 1'b1; ReadFlag = rf; WriteFlag = wf;
    ReadDataSelect = rsel; WriteDataSelect = wsel; addr = a; wdata = wd;
    k = cyc;
    e.err = eerr;
    e.rdata = erd;
    if (dly == -2)      e.cyc = k + 1;
    else if (dly == -1) e.cyc = k + 1 + TMO;
    else                e.cyc = k + 2 + dly;
    sb_q.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0; ReadFlag = 1'b0; WriteFlag = 1'b0;
    if (dly == -2) begin
      chk("no_mem_req", {31'd0, mem_req}, 32'd0);
      @(posedge clk); #1;
      chk("no_mem_req2", {31'd0, mem_req}, 32'd0);
    end else begin
      for (int i = 0; i < TMO; i++) begin
        chk_mem(ewe, eaddr, ebe, ewd);
        if (i == dly) begin
          mem_ack = 1'b1; mem_rdata = mrd;
          @(posedge clk); #1;
          mem_ack = 1'b0; mem_rdata = 32'h0;
          break;
        end
        @(posedge clk); #1;
      end
      chk("mem_req_drop", {31'd0, mem_req}, 32'd0);
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);

    // SB at byte 3, immediate ack
    do_access(1'b0, 1'b1, 3'b000, 2'b01, 32'h0000_1003, 32'h0000_00AB, 0, 32'hFFFF_FFFF,
              1'b1, 32'h0000_1000, 4'b1000, 32'hABAB_ABAB, 1'b0, 32'h0);
    // SH at upper half
    do_access(1'b0, 1'b1, 3'b000, 2'b10, 32'h0000_0012, 32'h1234_ABCD, 1, 32'hFFFF_FFFF,
              1'b1, 32'h0000_0010, 4'b1100, 32'hABCD_ABCD, 1'b0, 32'h0);
    // LB / LBU from lane 2
    do_access(1'b1, 1'b0, 3'b001, 2'b00, 32'h0000_2002, 32'h0, 0, 32'h12F4_5678,
              1'b0, 32'h0000_2000, 4'b1111, 32'h0, 1'b0, 32'hFFFF_FFF4);
    do_access(1'b1, 1'b0, 3'b010, 2'b00, 32'h0000_2002, 32'h0, 0, 32'h12F4_5678,
              1'b0, 32'h0000_2000, 4'b1111, 32'h0, 1'b0, 32'h0000_00F4);
    // LW passthrough
    do_access(1'b1, 1'b0, 3'b000, 2'b00, 32'h0000_2004, 32'h0, 2, 32'hDEAD_BEEF,
              1'b0, 32'h0000_2004, 4'b1111, 32'h0, 1'b0, 32'hDEAD_BEEF);
    // Rejected: misaligned LH, both flags, illegal load code, illegal store code
    do_access(1'b1, 1'b0, 3'b011, 2'b00, 32'h0000_2001, 32'h0, -2, 32'h0,
              1'b0, 32'h0, 4'b0000, 32'h0, 1'b1, 32'h0);
    do_access(1'b1, 1'b1, 3'b000, 2'b00, 32'h0000_2000, 32'h0, -2, 32'h0,
              1'b0, 32'h0, 4'b0000, 32'h0, 1'b1, 32'h0);
    do_access(1'b1, 1'b0, 3'b101, 2'b00, 32'h0000_2000, 32'h0, -2, 32'h0,
              1'b0, 32'h0, 4'b0000, 32'h0, 1'b1, 32'h0);
    do_access(1'b0, 1'b1, 3'b000, 2'b11, 32'h0000_2000, 32'h0, -2, 32'h0,
              1'b0, 32'h0, 4'b0000, 32'h0, 1'b1, 32'h0);
    // LHU upper half, ack delayed 5 cycles
    do_access(1'b1, 1'b0, 3'b100, 2'b00, 32'h0000_2002, 32'h0, 5, 32'h8001_7FFF,
              1'b0, 32'h0000_2000, 4'b1111, 32'h0, 1'b0, 32'h0000_8001);

    // Spurious ack while idle
    @(posedge clk); #1;
    mem_ack = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("idle_ack_resp", {31'd0, resp_valid}, 32'd0);
      chk("idle_ack_req", {31'd0, mem_req}, 32'd0);
    end
    mem_ack = 1'b0;

    // Timeout, then a normal LH with sign extension
    do_access(1'b1, 1'b0, 3'b000, 2'b00, 32'h0000_3000, 32'h0, -1, 32'h0,
              1'b0, 32'h0000_3000, 4'b1111, 32'h0, 1'b1, 32'h0);
    do_access(1'b1, 1'b0, 3'b011, 2'b00, 32'h0000_3002, 32'h0, 0, 32'hC0DE_1234,
              1'b0, 32'h0000_3000, 4'b1111, 32'h0, 1'b0, 32'hFFFF_C0DE);
    // Ack on the last allowed cycle wins
    do_access(1'b1, 1'b0, 3'b000, 2'b00, 32'h0000_3004, 32'h0, TMO - 1, 32'h0BAD_F00D,
              1'b0, 32'h0000_3004, 4'b1111, 32'h0, 1'b0, 32'h0BAD_F00D);

    // Reset in the middle of an access: no response expected
    wait_ready();
    req_valid = 1'b1; ReadFlag = 1'b1; ReadDataSelect = 3'b000; addr = 32'h0000_0080;
    @(posedge clk); #1;
    req_valid = 1'b0; ReadFlag = 1'b0;
    chk("pre_rst_mem_req", {31'd0, mem_req}, 32'd1);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_drop_mem_req", {31'd0, mem_req}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("post_rst_resp", {31'd0, resp_valid}, 32'd0);
    do_access(1'b0, 1'b1, 3'b000, 2'b00, 32'h0000_0040, 32'hCAFE_F00D, 0, 32'hFFFF_FFFF,
              1'b1, 32'h0000_0040, 4'b1111, 32'hCAFE_F00D, 1'b0, 32'h0);

    repeat (4) @(posedge clk);
    #1;
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
